// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the uart transmit path
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        ARB,
        ISSUE,
        WAIT_START,
        WAIT_DONE
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set request at or after ptr, wrapping
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any_valid,
    output logic [IW-1:0] grant
);

    logic [IW-1:0] idx;

    // Scan from the far end so the closest request to ptr is written last and wins.
    always_comb begin
        any_valid = 1'b0;
        grant     = '0;
        idx       = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = IW'((int'(ptr) + i) % N);
            if (req[idx]) begin
                any_valid = 1'b1;
                grant     = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin share of one uart_tx; UART_ARB_PKT_LOCK_EN adds packet lock
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*UART_BYTE_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [UART_BYTE_W-1:0]         tx_data,
    output logic                           transmit,
    input  logic                           tx_busy,
    output logic [ID_W-1:0]                grant_id,
    output logic                           active
);

    arb_state_t           state, state_nxt;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      pick;
    logic [ID_W-1:0]      pick_inc;
    logic                 any_valid;
    logic [NUM_REQ-1:0]   eligible;
    logic                 accept;
    logic                 adv_ptr;

`ifdef UART_ARB_PKT_LOCK_EN
    logic locked;

    // While a packet is open only its owner may be granted, valid or not.
    always_comb begin
        eligible = locked ? (req_valid & (NUM_REQ'(1) << grant_id)) : req_valid;
        adv_ptr  = accept && req_last[pick];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked <= 1'b0;
        end else if (accept) begin
            locked <= !req_last[pick];
        end
    end
`else
    logic unused_last;

    assign unused_last = ^req_last;

    always_comb begin
        eligible = req_valid;
        adv_ptr  = accept;
    end
`endif

    rr_pick #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_pick (
        .req       (eligible),
        .ptr       (rr_ptr),
        .any_valid (any_valid),
        .grant     (pick)
    );

    assign pick_inc = (pick == ID_W'(NUM_REQ - 1)) ? '0 : pick + ID_W'(1);

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        transmit  = 1'b0;
        accept    = 1'b0;
        case (state)
            ARB: begin
                if (rst_n && !tx_busy && any_valid) begin
                    accept    = 1'b1;
                    req_ready = NUM_REQ'(1) << pick;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                transmit  = 1'b1;
                state_nxt = WAIT_START;
            end
            WAIT_START: begin
                if (tx_busy) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!tx_busy) state_nxt = ARB;
            end
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB;
            rr_ptr   <= '0;
            tx_data  <= '0;
            grant_id <= '0;
            active   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                tx_data  <= req_data[int'(pick)*UART_BYTE_W +: UART_BYTE_W];
                grant_id <= pick;
                active   <= 1'b1;
            end else if (state == WAIT_DONE && !tx_busy) begin
                active <= 1'b0;
            end
            if (adv_ptr) rr_ptr <= pick_inc;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a behavioural uart_tx
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int BIT     = 8;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    logic                   clk;
    logic                   rst_n;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*8-1:0]   req_data;
    logic [NUM_REQ-1:0]     req_last;
    logic [NUM_REQ-1:0]     req_ready;
    logic [7:0]             tx_data;
    logic                   transmit;
    logic                   tx_busy;
    logic [ID_W-1:0]        grant_id;
    logic                   active;
    logic                   tx_line;

    logic [9:0]             u_sh;
    int                     u_tick;
    int                     u_bit;

    int                     n_chk;
    int                     n_pass;
    exp_t                   exp_acc[$];
    logic [7:0]             exp_line[$];

    logic [7:0]             src_data [NUM_REQ][16];
    logic                   src_lst  [NUM_REQ][16];
    int                     src_n    [NUM_REQ];
    int                     src_i    [NUM_REQ];

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .transmit  (transmit),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .active    (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural uart_tx: busy rises the cycle after transmit, 10 bits of BIT cycles each.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy <= 1'b0;
            tx_line <= 1'b1;
            u_sh    <= '1;
            u_tick  <= 0;
            u_bit   <= 0;
        end else if (!tx_busy) begin
            if (transmit) begin
                tx_busy <= 1'b1;
                u_sh    <= {1'b1, tx_data, 1'b0};
                tx_line <= 1'b0;
                u_tick  <= 0;
                u_bit   <= 0;
            end
        end else if (u_tick == BIT - 1) begin
            u_tick <= 0;
            if (u_bit == 9) begin
                tx_busy <= 1'b0;
                tx_line <= 1'b1;
            end else begin
                u_bit   <= u_bit + 1;
                tx_line <= u_sh[u_bit+1];
            end
        end else begin
            u_tick <= u_tick + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic expect_acc(input int id, input logic [7:0] d, input bit on_line);
        exp_acc.push_back('{id, d});
        if (on_line) exp_line.push_back(d);
    endtask

    task automatic load(input int id, input logic [7:0] d, input logic last);
        src_data[id][src_n[id]] = d;
        src_lst[id][src_n[id]]  = last;
        src_n[id]++;
    endtask

    task automatic neg_wait(input int n, output bit hit);
        hit = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (!rst_n) hit = 1'b1;
        end
    endtask

    task automatic wait_busy(input logic lvl, input string name);
        int n;
        n = 0;
        while (tx_busy !== lvl && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(tx_busy), int'(lvl));
    endtask

    task automatic wait_idle(input string name);
        int  n;
        bit  idle;
        n    = 0;
        idle = 1'b0;
        while (!idle && n < 6000) begin
            @(negedge clk);
            n++;
            idle = !active && !tx_busy && exp_acc.size() == 0;
            for (int i = 0; i < NUM_REQ; i++) if (src_i[i] != src_n[i]) idle = 1'b0;
        end
        chk(name, int'(idle), 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Requester models: present the head byte, advance after an accept.
    initial begin
        logic [NUM_REQ-1:0] acc;
        for (int i = 0; i < NUM_REQ; i++) src_i[i] = 0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            acc = req_ready & req_valid;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i]) src_i[i]++;
                req_valid[i] = (src_i[i] < src_n[i]);
                if (src_i[i] < 16) begin
                    req_data[8*i +: 8] = src_data[i][src_i[i]];
                    req_last[i]        = src_lst[i][src_i[i]];
                end
            end
        end
    end

    // Accept monitor: one-hot ready, grant index, then registered outputs and transmit next cycle.
    initial begin
        exp_t e;
        int   g;
        forever begin
            @(negedge clk);
            if (rst_n && req_ready != '0) begin
                chk("ready_onehot", $countones(req_ready), 1);
                g = 0;
                for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) g = i;
                chk("accept_pending", int'(exp_acc.size() != 0), 1);
                if (exp_acc.size() != 0) begin
                    e = exp_acc.pop_front();
                    chk("ready_index", g, e.id);
                    @(negedge clk);
                    chk("grant_id", int'(grant_id), e.id);
                    chk("tx_data", int'(tx_data), int'(e.data));
                    chk("transmit_next_cycle", int'(transmit), 1);
                    chk("active_after_accept", int'(active), 1);
                end
            end
        end
    end

    // Line monitor: decode each complete frame on tx_line, skip frames cut by reset.
    initial begin
        logic [7:0] b;
        logic       st;
        logic       sp;
        bit         ab;
        bit         hit;
        forever begin
            @(negedge clk);
            if (rst_n && tx_line === 1'b0) begin
                b = '0;
                neg_wait(BIT / 2, hit);
                ab = hit;
                st = tx_line;
                for (int k = 0; k < 8; k++) begin
                    neg_wait(BIT, hit);
                    ab = ab | hit;
                    b  = {tx_line, b[7:1]};
                end
                neg_wait(BIT, hit);
                ab = ab | hit;
                sp = tx_line;
                if (!ab) begin
                    chk("start_bit", int'(st), 0);
                    chk("stop_bit", int'(sp), 1);
                    chk("line_pending", int'(exp_line.size() != 0), 1);
                    if (exp_line.size() != 0) chk("line_byte", int'(b), int'(exp_line.pop_front()));
                end
            end
        end
    end

    // tx_data must not move while uart_tx is shifting a frame.
    initial begin
        logic [7:0] cap;
        bit         in_fr;
        bit         fr_bad;
        bit         fr_abort;
        logic       prev_busy;
        cap       = '0;
        in_fr     = 1'b0;
        fr_bad    = 1'b0;
        fr_abort  = 1'b0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) fr_abort = 1'b1;
            if (transmit) begin
                cap      = tx_data;
                in_fr    = 1'b1;
                fr_bad   = 1'b0;
                fr_abort = 1'b0;
            end
            if (tx_busy && tx_data !== cap) fr_bad = 1'b1;
            if (in_fr && prev_busy && !tx_busy) begin
                in_fr = 1'b0;
                if (!fr_abort) chk("tx_data_stable", int'(fr_bad), 0);
            end
            prev_busy = tx_busy;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_chk  = 0;
        n_pass = 0;
        for (int i = 0; i < NUM_REQ; i++) src_n[i] = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_transmit", int'(transmit), 0);
        chk("rst_grant_id", int'(grant_id), 0);
        chk("rst_active", int'(active), 0);
        rst_n = 1'b1;

        // single byte on requester 2
        expect_acc(2, 8'h48, 1'b1);
        load(2, 8'h48, 1'b1);
        wait_busy(1'b1, "t1_busy_rise");
        wait_busy(1'b0, "t1_busy_fall");
        @(negedge clk);
        chk("t1_active_drop", int'(active), 0);
        wait_idle("t1_idle");

        // all four continuously valid
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) expect_acc(i, 8'hA0 + 8'(i), 1'b1);
        for (int i = 0; i < NUM_REQ; i++) expect_acc(i, 8'hB0 + 8'(i), 1'b1);
        for (int i = 0; i < NUM_REQ; i++) begin
            load(i, 8'hA0 + 8'(i), 1'b1);
            load(i, 8'hB0 + 8'(i), 1'b1);
        end
        wait_idle("t2_idle");

        // pointer wrap 3 -> 0, then 1 wins over 3
        expect_acc(3, 8'hC3, 1'b1);
        load(3, 8'hC3, 1'b1);
        wait_idle("t3a_idle");
        expect_acc(0, 8'hC0, 1'b1);
        load(0, 8'hC0, 1'b1);
        wait_idle("t3b_idle");
        expect_acc(1, 8'hD1, 1'b1);
        expect_acc(3, 8'hD3, 1'b1);
        load(1, 8'hD1, 1'b1);
        load(3, 8'hD3, 1'b1);
        wait_idle("t3c_idle");

        // reset during data bit 4, then a normal request
        expect_acc(2, 8'h55, 1'b0);
        load(2, 8'h55, 1'b1);
        wait_busy(1'b1, "t4_busy_rise");
        repeat (5 * BIT + BIT / 2) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t4_transmit", int'(transmit), 0);
        chk("t4_active", int'(active), 0);
        chk("t4_tx_line", int'(tx_line), 1);
        chk("t4_ready", int'(req_ready), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (60) @(negedge clk);
        expect_acc(1, 8'h5A, 1'b1);
        load(1, 8'h5A, 1'b1);
        wait_idle("t4_idle");

        // back-to-back on one requester
        expect_acc(0, 8'h11, 1'b1);
        expect_acc(0, 8'h22, 1'b1);
        load(0, 8'h11, 1'b1);
        load(0, 8'h22, 1'b1);
        wait_busy(1'b1, "t5_busy_rise");
        wait_busy(1'b0, "t5_busy_fall");
        n = 1;
        while (!transmit && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_gap", n, 3);
        wait_idle("t5_idle");

        // three-byte packet on req0 while req1 is waiting
        do_reset();
`ifdef UART_ARB_PKT_LOCK_EN
        expect_acc(0, 8'hE0, 1'b1);
        expect_acc(0, 8'hE1, 1'b1);
        expect_acc(0, 8'hE2, 1'b1);
        expect_acc(1, 8'hF0, 1'b1);
        expect_acc(1, 8'hF1, 1'b1);
`else
        expect_acc(0, 8'hE0, 1'b1);
        expect_acc(1, 8'hF0, 1'b1);
        expect_acc(0, 8'hE1, 1'b1);
        expect_acc(1, 8'hF1, 1'b1);
        expect_acc(0, 8'hE2, 1'b1);
`endif
        load(0, 8'hE0, 1'b0);
        load(0, 8'hE1, 1'b0);
        load(0, 8'hE2, 1'b1);
        load(1, 8'hF0, 1'b1);
        load(1, 8'hF1, 1'b1);
        wait_idle("t6_idle");

        repeat (20) @(negedge clk);
        chk("acc_queue_empty", exp_acc.size(), 0);
        chk("line_queue_empty", exp_line.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
